// File: rtl/instr_mem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory read port between fetch (F) and data loads (D).
// One read in flight at a time; flushed fetches are drained silently, stalled reads are abandoned after TIMEOUT.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no read in flight; arbitrate eligible requests
// S_ISSUE | mem_start pulse is on the wire; memory response ignored
// S_WAIT  | waiting for mem_done or timeout; counting cycles
// S_ACK   | owner's ack/q pulse is on the wire; return to idle
module instr_mem_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   input  logic        f_flush,
   output logic        f_ack,
   output logic [31:0] f_q,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   output logic        d_ack,
   output logic [31:0] d_q,
   output logic        mem_start,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_q,
   output logic        busy,
   output logic        timeout_err
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

   state_t        r_state;
   logic          r_owner_d;
   logic          r_last_d;
   logic          r_drop;
   logic [CW-1:0] r_cnt;

   logic          w_f_elig;
   logic          w_d_elig;
   logic          w_grant_d;
   logic          w_flush_hit;
   logic          w_tmo;
   logic [31:0]   w_data;

   assign w_f_elig    = f_req & ~f_flush;
   assign w_d_elig    = d_req;
   // D wins only when F is not eligible or F took the previous grant
   assign w_grant_d   = w_d_elig & (~w_f_elig | ~r_last_d);
   assign w_flush_hit = ~r_owner_d & f_flush;
   assign w_tmo       = (r_cnt == CW'(TIMEOUT - 1));
   assign w_data      = mem_done ? mem_q : 32'd0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_owner_d   <= 1'b0;
         r_last_d    <= 1'b1;
         r_drop      <= 1'b0;
         r_cnt       <= '0;
         f_ack       <= 1'b0;
         f_q         <= 32'd0;
         d_ack       <= 1'b0;
         d_q         <= 32'd0;
         mem_start   <= 1'b0;
         mem_addr    <= 32'd0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         mem_start   <= 1'b0;
         f_ack       <= 1'b0;
         f_q         <= 32'd0;
         d_ack       <= 1'b0;
         d_q         <= 32'd0;
         timeout_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_f_elig || w_d_elig) begin
                  r_owner_d <= w_grant_d;
                  r_last_d  <= w_grant_d;
                  mem_addr  <= w_grant_d ? d_addr : f_addr;
                  r_drop    <= 1'b0;
                  r_cnt     <= '0;
                  mem_start <= 1'b1;
                  busy      <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_flush_hit) r_drop <= 1'b1;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_cnt != CW'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
               if (mem_done || w_tmo) begin
                  if (!mem_done) timeout_err <= 1'b1;
                  // a flushed fetch has drained the memory; skip the ack entirely
                  if (r_drop || w_flush_hit) begin
                     r_drop  <= 1'b1;
                     busy    <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     f_ack   <= ~r_owner_d;
                     d_ack   <= r_owner_d;
                     f_q     <= r_owner_d ? 32'd0 : w_data;
                     d_q     <= r_owner_d ? w_data : 32'd0;
                     r_state <= S_ACK;
                  end
               end else if (w_flush_hit) begin
                  r_drop <= 1'b1;
               end
            end
            S_ACK: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter: a latency-programmable memory responder and an
// expected-ack queue filled as requests are raised and drained as acks appear.
module tb_instr_mem_arbiter;
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        f_req, f_flush, f_ack, d_req, d_ack;
   logic        mem_start, mem_done, busy, timeout_err;
   logic [31:0] f_addr, f_q, d_addr, d_q, mem_addr, mem_q;

   always #5 clk = ~clk;

   instr_mem_arbiter #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_ack(f_ack), .f_q(f_q),
      .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_q(d_q),
      .mem_start(mem_start), .mem_addr(mem_addr), .mem_done(mem_done), .mem_q(mem_q),
      .busy(busy), .timeout_err(timeout_err)
   );

   typedef struct {
      logic        is_d;
      logic [31:0] q;
      logic        err;
      logic [31:0] addr;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          ack_total = 0;
   int          err_total = 0;
   int          q_leak = 0;
   int          start_cnt = 0;
   logic [31:0] start_addr = 32'd0;
   logic        r_resp_done = 1'b0;
   logic        r_stray = 1'b0;
   logic [31:0] r_resp_q = 32'd0;
   int          mem_lat = 1;
   bit          mem_en = 1'b1;
   bit          auto_q = 1'b1;
   logic [31:0] mem_q_val = 32'd0;

   assign mem_done = r_resp_done | r_stray;
   assign mem_q    = r_resp_q;

   function automatic logic [31:0] auto_data(input logic [31:0] a);
      return {a[15:0] ^ 16'hA5A5, a[15:0]};
   endfunction

   // memory model: mem_done asserted mem_lat negedges after mem_start is seen
   always begin
      @(negedge clk);
      if (mem_start) begin
         start_cnt++;
         start_addr = mem_addr;
         if (mem_en) begin
            repeat (mem_lat) @(negedge clk);
            r_resp_done = 1'b1;
            r_resp_q    = auto_q ? auto_data(start_addr) : mem_q_val;
            @(negedge clk);
            r_resp_done = 1'b0;
            r_resp_q    = 32'd0;
         end
      end
   end

   always @(negedge clk) begin
      if (f_ack) ack_total++;
      if (d_ack) ack_total++;
      if ((!f_ack && f_q != 32'd0) || (!d_ack && d_q != 32'd0)) q_leak++;
      if (timeout_err) err_total++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic is_d, input logic [31:0] addr, input logic [31:0] q,
                       input logic err);
      exp_t e;
      e.is_d = is_d;
      e.q    = q;
      e.err  = err;
      e.addr = addr;
      sb.push_back(e);
   endtask

   task automatic wait_ack(input string tag, input int max, output int cyc);
      bit   got;
      exp_t e;
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < max) begin
         @(negedge clk);
         cyc++;
         if (f_ack || d_ack) got = 1'b1;
      end
      checks++;
      assert (got) else begin
         failures++;
         $error("FAIL %s_ack_wait observed=no_ack expected=ack within %0d cycles", tag, max);
      end
      if (got) begin
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL %s_unexpected_ack observed=ack expected=none", tag);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_port"}, {30'd0, f_ack, d_ack}, e.is_d ? 32'd1 : 32'd2);
            chk({tag, "_q"}, e.is_d ? d_q : f_q, e.q);
            chk({tag, "_other_q"}, e.is_d ? f_q : d_q, 32'd0);
            chk({tag, "_err"}, {31'd0, timeout_err}, {31'd0, e.err});
            chk({tag, "_addr"}, start_addr, e.addr);
         end
      end
   endtask

   task automatic wait_start(input string tag);
      int n;
      n = 0;
      while (!mem_start && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      assert (mem_start) else begin
         failures++;
         $error("FAIL %s_start observed=0 expected=1", tag);
      end
   endtask

   initial begin
      int cyc, fi, di, sc0, ack0;
      reset = 1'b0; f_req = 1'b0; f_flush = 1'b0; d_req = 1'b0;
      f_addr = 32'd0; d_addr = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_outs", {28'd0, f_ack, d_ack, mem_start, timeout_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_q", f_q | d_q, 32'd0);
      reset = 1'b1;

      // contention: both held, F wins first tie, then strict alternation
      @(negedge clk);
      auto_q = 1'b1; mem_lat = 1; fi = 0; di = 0;
      f_addr = 32'h100; d_addr = 32'h200; f_req = 1'b1; d_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(1'b0, 32'h100 + 32'(4 * i), auto_data(32'h100 + 32'(4 * i)), 1'b0);
         push(1'b1, 32'h200 + 32'(4 * i), auto_data(32'h200 + 32'(4 * i)), 1'b0);
      end
      for (int t = 0; t < 8; t++) begin
         wait_ack("cont", 20, cyc);
         if (f_ack) begin
            fi++;
            if (fi == 4) f_req = 1'b0; else f_addr = 32'h100 + 32'(4 * fi);
         end
         if (d_ack) begin
            di++;
            if (di == 4) d_req = 1'b0; else d_addr = 32'h200 + 32'(4 * di);
         end
      end

      // single fetch
      @(negedge clk);
      sc0 = start_cnt; auto_q = 1'b0; mem_q_val = 32'hDEADBEEF; mem_lat = 2;
      f_addr = 32'h40; f_req = 1'b1;
      push(1'b0, 32'h40, 32'hDEADBEEF, 1'b0);
      wait_ack("fetch", 20, cyc);
      f_req = 1'b0;
      chk("fetch_latency", 32'(cyc), 32'd4);
      chk("fetch_maddr", mem_addr, 32'h40);
      repeat (3) @(negedge clk);
      chk("fetch_starts", 32'(start_cnt - sc0), 32'd1);
      chk("fetch_idle_busy", {31'd0, busy}, 32'd0);

      // flush in WAIT; pending D is served next with no F ack
      mem_q_val = 32'h12345678; mem_lat = 3; f_addr = 32'h80; f_req = 1'b1;
      wait_start("flush");
      d_addr = 32'h300; d_req = 1'b1;
      push(1'b1, 32'h300, 32'h12345678, 1'b0);
      @(negedge clk);
      f_flush = 1'b1; f_req = 1'b0;
      @(negedge clk);
      f_flush = 1'b0;
      wait_ack("flush", 30, cyc);
      d_req = 1'b0;

      // timeout with no memory response, then mem_done on the last WAIT cycle
      @(negedge clk);
      mem_en = 1'b0; f_addr = 32'h44; f_req = 1'b1;
      push(1'b0, 32'h44, 32'd0, 1'b1);
      wait_ack("tmo", 20, cyc);
      f_req = 1'b0;
      chk("tmo_latency", 32'(cyc), 32'(TMO + 2));
      repeat (2) @(negedge clk);
      mem_en = 1'b1; auto_q = 1'b1; mem_lat = TMO; f_addr = 32'h60; f_req = 1'b1;
      push(1'b0, 32'h60, auto_data(32'h60), 1'b0);
      wait_ack("tmo_edge", 20, cyc);
      f_req = 1'b0;
      chk("tmo_edge_latency", 32'(cyc), 32'(TMO + 2));

      // reset while in WAIT; late mem_done lands in IDLE
      repeat (2) @(negedge clk);
      mem_lat = 5; f_addr = 32'h48; f_req = 1'b1;
      wait_start("rstw");
      @(negedge clk);
      reset = 1'b0; f_req = 1'b0;
      @(negedge clk);
      chk("rstw_outs", {28'd0, f_ack, d_ack, mem_start, timeout_err}, 32'd0);
      chk("rstw_busy", {31'd0, busy}, 32'd0);
      chk("rstw_addr", mem_addr, 32'd0);
      ack0 = ack_total;
      @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      chk("rstw_no_ack", 32'(ack_total), 32'(ack0));
      chk("rstw_idle", {31'd0, busy}, 32'd0);
      mem_lat = 1; f_addr = 32'h4C; d_addr = 32'h304; f_req = 1'b1; d_req = 1'b1;
      push(1'b0, 32'h4C, auto_data(32'h4C), 1'b0);
      push(1'b1, 32'h304, auto_data(32'h304), 1'b0);
      for (int t = 0; t < 2; t++) begin
         wait_ack("rstw_tie", 20, cyc);
         if (f_ack) f_req = 1'b0;
         if (d_ack) d_req = 1'b0;
      end

      // stray mem_done in IDLE, then F held off while f_flush is high
      repeat (2) @(negedge clk);
      ack0 = ack_total; sc0 = start_cnt;
      r_stray = 1'b1;
      @(negedge clk);
      r_stray = 1'b0;
      f_addr = 32'h50; f_req = 1'b1; f_flush = 1'b1;
      repeat (5) @(negedge clk);
      chk("stray_no_ack", 32'(ack_total), 32'(ack0));
      chk("flush_hold_busy", {31'd0, busy}, 32'd0);
      chk("flush_hold_starts", 32'(start_cnt), 32'(sc0));
      f_flush = 1'b0;
      push(1'b0, 32'h50, auto_data(32'h50), 1'b0);
      wait_ack("after_flush", 20, cyc);
      f_req = 1'b0;

      repeat (4) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("ack_total", 32'(ack_total), 32'd15);
      chk("err_total", 32'(err_total), 32'd1);
      chk("q_leak", 32'(q_leak), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/instr_mem_arbiter.md
# instr_mem_arbiter

Shares one instruction-memory read port between the CPU fetch stage (F) and the data-side load path (D), which reads constants out of instruction memory. It arbitrates round-robin, issues one read at a time to a variable-latency memory, and returns the word with a one-cycle ack pulse. It supports fetch flush on a pipeline clear and abandons reads that time out. It sits between the CPU fetch/load logic and the memory controller.

## Interface
- TIMEOUT, 15: max cycles spent in WAIT before abandoning a read; must be ≥ 1.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch read request; held high with stable f_addr until f_ack.
- f_addr  in  32  fetch byte address.
- f_flush  in  1  pipeline clear; cancels fetch delivery.
- f_ack  out  1  one-cycle pulse; f_q valid this cycle.
- f_q  out  32  fetch data; 0 whenever f_ack is low.
- d_req  in  1  data read request; held high with stable d_addr until d_ack.
- d_addr  in  32  data byte address.
- d_ack  out  1  one-cycle pulse; d_q valid this cycle.
- d_q  out  32  data word; 0 whenever d_ack is low.
- mem_start  out  1  one-cycle read strobe to memory.
- mem_addr  out  32  latched address of the owner; held until the next grant.
- mem_done  in  1  one-cycle pulse; mem_q valid.
- mem_q  in  32  memory read data.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  one-cycle pulse when a read is abandoned.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- IDLE: with no request pending, stay in IDLE. Otherwise:
  - Eligible requests: d_req, and f_req only when f_flush is low.
  - If only one request is eligible, grant it.
  - If both are eligible, grant the requester that did not win the last grant. last_grant resets to D, so F wins the first tie.
  - On grant: latch owner, set mem_addr to the owner's address, clear drop and cnt, update last_grant, go to ISSUE.
- ISSUE: assert mem_start for exactly one cycle, go to WAIT. mem_done in this cycle is ignored.
- WAIT: cnt increments every cycle.
  - mem_done = 1: capture mem_q and go to ACK.
  - Otherwise, cnt == TIMEOUT-1: pulse timeout_err, capture 0 as data, go to ACK.
  - mem_done and the timeout condition in the same cycle: mem_done wins, no error.
- Flush: f_flush high in any ISSUE or WAIT cycle while the owner is F sets drop.
  - A dropped read still waits for mem_done or the timeout, so the memory stays consistent.
  - It then returns to IDLE with no f_ack and f_q = 0; the ACK cycle is skipped.
  - f_flush while the owner is D has no effect.
- ACK: pulse the owner's ack with its q = captured word; the other port's ack and q stay 0. Next state is IDLE.
  - f_flush during the ACK cycle does not retract an ack already issued.
- mem_done in IDLE or ACK is discarded.
- cnt width is clog2(TIMEOUT+1). cnt saturates and never wraps.

## Timing
- Reset (asynchronous, low): state = IDLE, last_grant = D, drop = 0, cnt = 0. All outputs are 0, including mem_addr.
- Reset mid-transaction: the read is abandoned with no ack. A late mem_done arrives in IDLE and is ignored.
- Request sampled at edge E0 (IDLE) → mem_start high in cycle E0+1 → WAIT from E0+2.
- mem_done sampled in WAIT at edge Ek → ack high in cycle Ek+1. Minimum request-to-ack is 3 cycles with mem_done sampled at E0+2.
- After ack, the requester drops req at the edge that samples ack. The FSM is in IDLE one cycle later, so a held req is never double-granted.
- Back-to-back: a new grant is possible at the first IDLE edge after ACK, giving at most 1 idle cycle between transactions.
- Timeout: with no mem_done, timeout_err and ack assert in the same cycle, exactly TIMEOUT+2 cycles after the grant edge.

## Test plan
- Single fetch: f_req, f_addr = 0x40, mem_done 2 cycles after mem_start with mem_q = 0xDEADBEEF → mem_addr = 0x40, one mem_start, f_ack 1 cycle with f_q = 0xDEADBEEF, d_ack = 0, d_q = 0.
- Contention: f_req and d_req asserted together and held through 4 transactions each → grant order F,D,F,D,…; no requester waits more than one transaction.
- Flush: F granted, f_flush pulsed in WAIT, mem_done later with 0x12345678 → no f_ack, f_q stays 0; a pending d_req is granted next.
- Timeout with TIMEOUT = 4: mem_done never asserted → timeout_err and f_ack high together, f_q = 0, 6 cycles after the grant edge. mem_done coincident with the last WAIT cycle → normal ack, no error.
- Reset in WAIT: reset pulsed low, then mem_done arrives → all outputs 0, no ack, next request served normally with last_grant = D.
- Stray mem_done in IDLE, and f_flush held with f_req in IDLE → no ack, F is not granted until f_flush falls.
